// File: rtl/ccr_unit_if.sv
// Condition-code register stage bus.
// Master drives EX-stage strobes, slave returns CCR state.
interface ccr_unit_if #(
  parameter int CW = 3
);
  logic [2:0]    flags_in;
  logic          upd_z;
  logic          upd_n;
  logic          upd_c;
  logic          setc;
  logic          clrc;
  logic          jz;
  logic          jn;
  logic          jc;
  logic          jmp;
  logic          save;
  logic          restore;
  logic          stall;
  logic          flush;
  logic [2:0]    ccr;
  logic          branch_taken;
  logic [CW-1:0] depth;
  logic          save_ovf;
  logic          restore_unf;

  modport master (
    output flags_in, upd_z, upd_n, upd_c,
    output setc, clrc, jz, jn, jc, jmp,
    output save, restore, stall, flush,
    input  ccr, branch_taken, depth,
    input  save_ovf, restore_unf
  );

  modport slave (
    input  flags_in, upd_z, upd_n, upd_c,
    input  setc, clrc, jz, jn, jc, jmp,
    input  save, restore, stall, flush,
    output ccr, branch_taken, depth,
    output save_ovf, restore_unf
  );
endinterface

// File: rtl/ccr_unit.sv
// Condition-code register after the EX ALU.
// Flag latch, jump resolve, LIFO save/restore.
module ccr_unit #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic       clk,
  input logic       rst_n,
  ccr_unit_if.slave bus
);

  logic [2:0]    ccr_q, ccr_d;
  logic [CW-1:0] depth_q, depth_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic [2:0]    stack_q [DEPTH];
  logic [2:0]    stack_d [DEPTH];

  logic       valid;
  logic       taken;
  logic       push;
  logic       pop;
  logic       full;
  logic       empty;
  logic [2:0] n;
  logic [2:0] top;

  // Jump decision from registered flags only
  always_comb begin
    valid = !bus.stall & !bus.flush;
    taken = valid & (bus.jmp
          | (bus.jz & ccr_q[0])
          | (bus.jn & ccr_q[1])
          | (bus.jc & ccr_q[2]));
  end

  // Next CCR, stack and sticky error state
  always_comb begin
    n = ccr_q;
    if (bus.upd_z) n[0] = bus.flags_in[0];
    if (bus.upd_n) n[1] = bus.flags_in[1];
    if (bus.upd_c) n[2] = bus.flags_in[2];
    if (bus.setc)  n[2] = 1'b1;
    if (bus.clrc)  n[2] = 1'b0;
    if (bus.jz & ccr_q[0]) n[0] = 1'b0;
    if (bus.jn & ccr_q[1]) n[1] = 1'b0;
    if (bus.jc & ccr_q[2]) n[2] = 1'b0;

    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (depth_q == CW'(i + 1)) top = stack_q[i];
    end

    full  = depth_q >= CW'(DEPTH);
    empty = depth_q == '0;
    push  = valid & bus.save & !bus.restore;
    pop   = valid & bus.restore & !bus.save;

    ccr_d   = valid ? n : ccr_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    stack_d = stack_q;

    if (push) begin
      if (!full) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (depth_q == CW'(i)) stack_d[i] = ccr_q;
        end
        depth_d = depth_q + CW'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end

    if (pop) begin
      if (!empty) begin
        ccr_d   = top;
        depth_d = depth_q - CW'(1);
      end else begin
        unf_d = 1'b1;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccr_q   <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
    end else begin
      ccr_q   <= ccr_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      stack_q <= stack_d;
    end
  end

  assign bus.ccr          = ccr_q;
  assign bus.branch_taken = taken;
  assign bus.depth        = depth_q;
  assign bus.save_ovf     = ovf_q;
  assign bus.restore_unf  = unf_q;

endmodule

// File: tb/tb_ccr_unit.sv
// Bench for ccr_unit: queue-based flag/stack model
// checked every cycle, plus directed literal checks.
module tb_ccr_unit;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;

  ccr_unit_if #(.CW(CW)) bus ();

  ccr_unit #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, int act, int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask

  // Reference model: flags as bits, save stack as a queue
  logic [2:0] m_ccr;
  logic [2:0] m_stk[$];
  logic       m_ovf;
  logic       m_unf;

  function automatic bit m_valid();
    return !bus.stall && !bus.flush;
  endfunction

  function automatic bit m_taken();
    if (!m_valid()) return 1'b0;
    if (bus.jmp) return 1'b1;
    if (bus.jz && m_ccr[0]) return 1'b1;
    if (bus.jn && m_ccr[1]) return 1'b1;
    if (bus.jc && m_ccr[2]) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    logic [2:0] nx;
    if (!rst_n) begin
      m_ccr = '0;
      m_stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (m_valid()) begin
      nx = m_ccr;
      if (bus.upd_z) nx[0] = bus.flags_in[0];
      if (bus.upd_n) nx[1] = bus.flags_in[1];
      if (bus.upd_c) nx[2] = bus.flags_in[2];
      if (bus.setc) nx[2] = 1'b1;
      if (bus.clrc) nx[2] = 1'b0;
      if (bus.jz && m_ccr[0]) nx[0] = 1'b0;
      if (bus.jn && m_ccr[1]) nx[1] = 1'b0;
      if (bus.jc && m_ccr[2]) nx[2] = 1'b0;
      if (bus.save && !bus.restore) begin
        if (m_stk.size() < DEPTH) m_stk.push_back(m_ccr);
        else m_ovf = 1'b1;
      end
      if (bus.restore && !bus.save) begin
        if (m_stk.size() > 0) nx = m_stk.pop_back();
        else m_unf = 1'b1;
      end
      m_ccr = nx;
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    chk("ccr", int'(bus.ccr), int'(m_ccr));
    chk("depth", int'(bus.depth), m_stk.size());
    chk("save_ovf", int'(bus.save_ovf), int'(m_ovf));
    chk("restore_unf", int'(bus.restore_unf), int'(m_unf));
    chk("branch_taken", int'(bus.branch_taken), int'(m_taken()));
  end

  task automatic idle();
    bus.flags_in = '0;
    bus.upd_z = 0; bus.upd_n = 0; bus.upd_c = 0;
    bus.setc = 0;  bus.clrc = 0;
    bus.jz = 0; bus.jn = 0; bus.jc = 0; bus.jmp = 0;
    bus.save = 0; bus.restore = 0;
    bus.stall = 0; bus.flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic load(logic [2:0] f);
    bus.upd_z = 1; bus.upd_n = 1; bus.upd_c = 1;
    bus.flags_in = f;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    idle();
    rst_n = 1'b0;
    bus.flags_in = 3'b111;
    bus.upd_z = 1; bus.upd_n = 1; bus.upd_c = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_ccr", int'(bus.ccr), 0);
    chk("rst_depth", int'(bus.depth), 0);
    idle();
    rst_n = 1'b1;

    load(3'b101); tick();
    chk("load101", int'(bus.ccr), 5);
    bus.upd_n = 1; bus.flags_in = 3'b010; tick();
    chk("upd_n", int'(bus.ccr), 7);
    bus.setc = 1; bus.clrc = 1; tick();
    chk("clrc_wins", int'(bus.ccr), 3);
    bus.setc = 1; tick();
    chk("setc", int'(bus.ccr), 7);

    load(3'b001); tick();
    bus.jz = 1; #1;
    chk("jz_taken", int'(bus.branch_taken), 1);
    tick();
    chk("jz_clear", int'(bus.ccr), 0);
    bus.jc = 1; #1;
    chk("jc_not", int'(bus.branch_taken), 0);
    tick();
    chk("jc_ccr", int'(bus.ccr), 0);
    bus.jmp = 1; #1;
    chk("jmp_taken", int'(bus.branch_taken), 1);
    tick();
    chk("jmp_ccr", int'(bus.ccr), 0);

    load(3'b001); tick();
    bus.jz = 1; bus.stall = 1; #1;
    chk("stall_bt", int'(bus.branch_taken), 0);
    tick();
    chk("stall_ccr", int'(bus.ccr), 1);
    bus.jz = 1; bus.flush = 1;
    bus.upd_z = 1; bus.flags_in = 3'b000; #1;
    chk("flush_bt", int'(bus.branch_taken), 0);
    tick();
    chk("flush_ccr", int'(bus.ccr), 1);

    bus.save = 1; load(3'b010); tick();
    bus.save = 1; load(3'b100); tick();
    bus.save = 1; load(3'b000); tick();
    chk("push3_depth", int'(bus.depth), 3);
    bus.restore = 1; tick();
    chk("pop1", int'(bus.ccr), 4);
    bus.restore = 1; tick();
    chk("pop2", int'(bus.ccr), 2);
    bus.restore = 1; tick();
    chk("pop3", int'(bus.ccr), 1);
    chk("pop3_depth", int'(bus.depth), 0);
    bus.restore = 1; tick();
    chk("unf", int'(bus.restore_unf), 1);
    chk("unf_ccr", int'(bus.ccr), 1);

    for (int i = 0; i < 5; i++) begin
      bus.save = 1; tick();
    end
    chk("ovf_depth", int'(bus.depth), 4);
    chk("ovf", int'(bus.save_ovf), 1);
    bus.save = 1; bus.restore = 1; tick();
    chk("both_depth", int'(bus.depth), 4);

    rst_n = 1'b0; #1;
    chk("arst_ccr", int'(bus.ccr), 0);
    chk("arst_depth", int'(bus.depth), 0);
    chk("arst_ovf", int'(bus.save_ovf), 0);
    chk("arst_unf", int'(bus.restore_unf), 0);
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 60; i++) begin
      bus.flags_in = 3'($urandom_range(0, 7));
      bus.upd_z = 1'($urandom_range(0, 1));
      bus.upd_n = 1'($urandom_range(0, 1));
      bus.upd_c = 1'($urandom_range(0, 1));
      bus.setc = ($urandom_range(0, 5) == 0);
      bus.clrc = ($urandom_range(0, 5) == 0);
      bus.jz = ($urandom_range(0, 3) == 0);
      bus.jn = ($urandom_range(0, 3) == 0);
      bus.jc = ($urandom_range(0, 3) == 0);
      bus.jmp = ($urandom_range(0, 7) == 0);
      bus.save = ($urandom_range(0, 2) == 0);
      bus.restore = ($urandom_range(0, 2) == 0);
      bus.stall = ($urandom_range(0, 7) == 0);
      bus.flush = ($urandom_range(0, 7) == 0);
      tick();
    end

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/ccr_unit.md
Name: ccr_unit

Overview:
- Condition-code register stage directly downstream of the execute-stage ALU.
- Latches the ALU's combinational Z/N/C flags under per-flag update enables and applies SETC/CLRC.
- Resolves conditional jumps (JZ/JN/JC/JMP) against the registered flags and clears the tested flag when a conditional jump is taken.
- Saves and restores the CCR on a small LIFO for interrupt entry and RTI.

Parameters:
- DEPTH, 4, number of CCR save-stack entries (>=1).
- CW, 3, stack-count width; must satisfy 2^CW > DEPTH.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flags_in  in  3  ALU flags: [0]=Z, [1]=N, [2]=C.
- upd_z  in  1  write flags_in[0] into CCR.Z this cycle.
- upd_n  in  1  write flags_in[1] into CCR.N this cycle.
- upd_c  in  1  write flags_in[2] into CCR.C this cycle.
- setc  in  1  force C=1.
- clrc  in  1  force C=0; wins over setc.
- jz  in  1  EX instruction is JZ.
- jn  in  1  EX instruction is JN.
- jc  in  1  EX instruction is JC.
- jmp  in  1  EX instruction is an unconditional jump.
- save  in  1  interrupt entry; push CCR.
- restore  in  1  RTI; pop into CCR.
- stall  in  1  EX stage frozen.
- flush  in  1  EX instruction squashed.
- ccr  out  3  registered CCR, same bit order as flags_in.
- branch_taken  out  1  combinational jump decision.
- depth  out  CW  stack entry count.
- save_ovf  out  1  sticky: push attempted while full.
- restore_unf  out  1  sticky: pop attempted while empty.

Behaviour:
- Reset (async, rst_n=0): ccr=3'b000, depth=0, save_ovf=0, restore_unf=0, stack contents don't-care. Outputs take these values immediately, not at the next edge.
- Qualifier: valid = !stall & !flush.
- When valid=0: no CCR change, no stack change, no error-flag change; branch_taken=0.
- branch_taken = valid & (jmp | (jz&ccr[0]) | (jn&ccr[1]) | (jc&ccr[2])). It uses registered ccr only, is combinational, and has zero latency.
- Next-CCR computation when valid, in this order:
  1. n = ccr.
  2. For each flag with its upd_x high, n.x = flags_in.x.
  3. If setc, n.C = 1. If clrc, n.C = 0.
  4. If branch_taken and the instruction was JZ, n.Z = 0. JN clears n.N; JC clears n.C. jmp clears nothing. If several jump strobes are high, every tested flag that was 1 is cleared.
  5. ccr <= n.
- save alone (valid):
  - If depth<DEPTH: stack[depth] <= ccr (pre-update value), depth+1.
  - Else the push is dropped, save_ovf <= 1, depth unchanged.
  - The CCR update above still applies.
- restore alone (valid):
  - If depth>0: ccr <= stack[depth-1], depth-1. The restored value overrides steps 1-5 entirely.
  - Else restore_unf <= 1, depth unchanged, steps 1-5 apply.
- save and restore in the same valid cycle: no stack change, no error flag set, steps 1-5 apply.
- Stack ordering is LIFO and supports nesting up to DEPTH levels.
- save_ovf and restore_unf are sticky until reset.
- Reset asserted mid-operation: everything returns to reset values asynchronously. Stack contents are invalid after reset.
- Latency: flags from an ALU op in cycle t are visible on ccr in cycle t+1. A dependent jump in t+1 sees them with no bypass needed.

Test Plan:
- Reset then update: rst_n=0 with flags_in=3'b111 → ccr=000, depth=0. Release reset, upd_z=upd_n=upd_c=1, flags_in=3'b101 → ccr=101 next cycle.
- Partial update and carry control:
  - ccr=101, upd_n=1, flags_in=3'b010 → ccr=111.
  - setc=1 and clrc=1 together → ccr=011.
  - setc alone → ccr=111.
- Jump clear:
  - ccr=001, jz=1 → branch_taken=1 same cycle, ccr=000 next.
  - jc=1 with C=0 → branch_taken=0, ccr unchanged.
  - jmp=1 → branch_taken=1, ccr unchanged.
- Stall/flush gating: ccr=001, jz=1, stall=1 → branch_taken=0, ccr stays 001. Same stimulus with flush=1 and upd_z=1, flags_in=0 → no change.
- Nested save/restore with DEPTH=4:
  - Push ccr values 001, 010, 100 → depth=3.
  - Three restores → ccr=100, then 010, then 001; depth=0.
  - Fourth restore → restore_unf=1, ccr unchanged.
- Overflow and simultaneous strobes:
  - Five saves → depth=4, save_ovf=1.
  - save+restore in one cycle → depth stays 4, no new error.
  - rst_n pulse mid-sequence → all outputs zero immediately.
